// File: rtl/data_path.sv
// 32-bit datapath slice: 32x32 register file with asynchronous reads feeding an ALU
// whose result and flags are captured on each clock edge in ALU mode.
module data_path #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGS  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] irInput,
  input  logic [WIDTH-1:0] dataInput,
  input  logic             registerFileSelect,
  output logic [WIDTH-1:0] regA,
  output logic [WIDTH-1:0] regB,
  output logic [WIDTH-1:0] aluResult,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam logic [5:0] OpAdd   = 6'b000000;
  localparam logic [5:0] OpSub   = 6'b000001;
  localparam logic [5:0] OpAnd   = 6'b000010;
  localparam logic [5:0] OpOr    = 6'b000011;
  localparam logic [5:0] OpXor   = 6'b000100;
  localparam logic [5:0] OpNor   = 6'b000101;
  localparam logic [5:0] OpSlt   = 6'b000110;
  localparam logic [5:0] OpSll   = 6'b000111;
  localparam logic [5:0] OpSrl   = 6'b001000;
  localparam logic [5:0] OpSra   = 6'b001001;
  localparam logic [5:0] OpPassA = 6'b001010;
  localparam logic [5:0] OpPassB = 6'b001011;

  logic [WIDTH-1:0] r_regs [REGS];
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;

  logic [5:0]       w_op;
  logic [4:0]       w_wa;
  logic [4:0]       w_ra;
  logic [4:0]       w_rb;
  logic [4:0]       w_shamt;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_ovf;
  logic             w_unused_ir;

  assign w_op    = irInput[31:26];
  assign w_wa    = irInput[25:21];
  assign w_ra    = irInput[20:16];
  assign w_rb    = irInput[15:11];
  assign w_shamt = regB[4:0];
  // Low instruction bits carry no meaning here; X on them must not reach any output.
  assign w_unused_ir = ^irInput[10:0];

  assign regA = r_regs[w_ra];
  assign regB = r_regs[w_rb];

  // SUB shares the adder as A + ~B + 1 so carry reads as NOT borrow.
  assign w_b_eff = (w_op == OpSub) ? ~regB : regB;
  assign w_sum   = {1'b0, regA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, (w_op == OpSub)};

  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    case (w_op)
      OpAdd, OpSub: begin
        w_result = w_sum[WIDTH-1:0];
        w_carry  = w_sum[WIDTH];
        w_ovf    = (regA[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != regA[WIDTH-1]);
      end
      OpAnd:   w_result = regA & regB;
      OpOr:    w_result = regA | regB;
      OpXor:   w_result = regA ^ regB;
      OpNor:   w_result = ~(regA | regB);
      OpSlt:   w_result = {{(WIDTH-1){1'b0}}, ($signed(regA) < $signed(regB))};
      OpSll:   w_result = regA << w_shamt;
      OpSrl:   w_result = regA >> w_shamt;
      OpSra:   w_result = $signed(regA) >>> w_shamt;
      OpPassA: w_result = regA;
      OpPassB: w_result = regB;
      default: begin
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (registerFileSelect) begin
      r_regs[w_wa] <= dataInput;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (!registerFileSelect) begin
      r_result <= w_result;
      r_zero   <= (w_result == '0);
      r_carry  <= w_carry;
      r_ovf    <= w_ovf;
    end
  end

  assign aluResult = r_result;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path: one task per feature, inline comparisons
// against hand-computed values.
module tb_data_path;

  localparam logic [5:0] OpAdd   = 6'b000000;
  localparam logic [5:0] OpSub   = 6'b000001;
  localparam logic [5:0] OpAnd   = 6'b000010;
  localparam logic [5:0] OpOr    = 6'b000011;
  localparam logic [5:0] OpXor   = 6'b000100;
  localparam logic [5:0] OpNor   = 6'b000101;
  localparam logic [5:0] OpSlt   = 6'b000110;
  localparam logic [5:0] OpSll   = 6'b000111;
  localparam logic [5:0] OpSrl   = 6'b001000;
  localparam logic [5:0] OpSra   = 6'b001001;
  localparam logic [5:0] OpPassA = 6'b001010;
  localparam logic [5:0] OpPassB = 6'b001011;
  localparam logic [5:0] OpBad   = 6'b111111;

  logic        clk;
  logic        reset;
  logic [31:0] irInput;
  logic [31:0] dataInput;
  logic        registerFileSelect;
  logic [31:0] regA;
  logic [31:0] regB;
  logic [31:0] aluResult;
  logic        zero;
  logic        carry;
  logic        overflow;

  int n_cmp;
  int n_err;

  data_path #(.WIDTH(32), .REGS(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .irInput            (irInput),
    .dataInput          (dataInput),
    .registerFileSelect (registerFileSelect),
    .regA               (regA),
    .regB               (regB),
    .aluResult          (aluResult),
    .zero               (zero),
    .carry              (carry),
    .overflow           (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Unused low bits are driven to X deliberately.
  function automatic logic [31:0] mk_ir(logic [5:0] op, logic [4:0] wa, logic [4:0] ra,
                                        logic [4:0] rb);
    return {op, wa, ra, rb, 11'bx};
  endfunction

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    registerFileSelect = 1'b1;
    irInput            = mk_ir(OpAdd, addr, 5'd0, 5'd0);
    dataInput          = data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_alu(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    registerFileSelect = 1'b0;
    irInput            = mk_ir(op, 5'd0, a, b);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_write(5'd1, 32'hFFFF_FFFF);
    do_alu(OpAdd, 5'd1, 5'd1);
    n_cmp++;
    if (aluResult !== 32'hFFFF_FFFE || carry !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_state: actual=%h/%b required=fffffffe/1", aluResult, carry);
    end
    @(negedge clk);
    irInput = mk_ir(OpAdd, 5'd0, 5'd1, 5'd1);
    reset   = 1'b1;
    #1;
    n_cmp++;
    if (aluResult !== 32'h0 || zero !== 1'b1 || carry !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_alu: actual=%h z%b c%b v%b required=0 z1 c0 v0",
               aluResult, zero, carry, overflow);
    end
    for (int i = 0; i < 32; i++) begin
      irInput = mk_ir(OpAdd, 5'd0, 5'(i), 5'(31 - i));
      #1;
      n_cmp++;
      if (regA !== 32'h0 || regB !== 32'h0) begin
        n_err++;
        $display("FAIL reset_reg%0d: actual=%h/%h required=0/0", i, regA, regB);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    do_alu(OpAdd, 5'd0, 5'd1);
    n_cmp++;
    if (aluResult !== 32'h0 || zero !== 1'b1 || carry !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_hold: actual=%h z%b c%b required=0 z1 c0",
               aluResult, zero, carry);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd0, 32'd1);
    do_write(5'd1, 32'd1);
    @(negedge clk);
    registerFileSelect = 1'b0;
    irInput            = mk_ir(OpAdd, 5'd0, 5'd0, 5'd1);
    #1;
    n_cmp++;
    if (regA !== 32'd1 || regB !== 32'd1) begin
      n_err++;
      $display("FAIL read_r0_r1: actual=%h/%h required=1/1", regA, regB);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (aluResult !== 32'd2 || zero !== 1'b0 || carry !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL add_1_1: actual=%h z%b c%b v%b required=2 z0 c0 v0",
               aluResult, zero, carry, overflow);
    end
  endtask

  task automatic test_overflow_carry();
    do_write(5'd2, 32'h7FFF_FFFF);
    do_write(5'd3, 32'd1);
    do_write(5'd4, 32'hFFFF_FFFF);
    do_alu(OpAdd, 5'd2, 5'd3);
    n_cmp++;
    if (aluResult !== 32'h8000_0000 || overflow !== 1'b1 || carry !== 1'b0 || zero !== 1'b0)
    begin
      n_err++;
      $display("FAIL add_ovf: actual=%h v%b c%b z%b required=80000000 v1 c0 z0",
               aluResult, overflow, carry, zero);
    end
    do_alu(OpAdd, 5'd4, 5'd3);
    n_cmp++;
    if (aluResult !== 32'h0 || zero !== 1'b1 || carry !== 1'b1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL add_carry: actual=%h z%b c%b v%b required=0 z1 c1 v0",
               aluResult, zero, carry, overflow);
    end
  endtask

  task automatic test_sub_slt();
    do_write(5'd5, 32'd3);
    do_write(5'd6, 32'd5);
    do_alu(OpSub, 5'd5, 5'd6);
    n_cmp++;
    if (aluResult !== 32'hFFFF_FFFE || carry !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL sub_3_5: actual=%h c%b v%b required=fffffffe c0 v0",
               aluResult, carry, overflow);
    end
    do_alu(OpSub, 5'd6, 5'd5);
    n_cmp++;
    if (aluResult !== 32'd2 || carry !== 1'b1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL sub_5_3: actual=%h c%b v%b required=2 c1 v0", aluResult, carry, overflow);
    end
    // 0x80000000 - 1 overflows in signed arithmetic.
    do_write(5'd15, 32'h8000_0000);
    do_alu(OpSub, 5'd15, 5'd3);
    n_cmp++;
    if (aluResult !== 32'h7FFF_FFFF || carry !== 1'b1 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL sub_ovf: actual=%h c%b v%b required=7fffffff c1 v1",
               aluResult, carry, overflow);
    end
    do_alu(OpSlt, 5'd4, 5'd3);
    n_cmp++;
    if (aluResult !== 32'd1 || carry !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL slt_m1_1: actual=%h c%b v%b required=1 c0 v0", aluResult, carry, overflow);
    end
    do_alu(OpSlt, 5'd3, 5'd4);
    n_cmp++;
    if (aluResult !== 32'd0 || zero !== 1'b1) begin
      n_err++;
      $display("FAIL slt_1_m1: actual=%h z%b required=0 z1", aluResult, zero);
    end
  endtask

  task automatic test_shift_logic();
    do_write(5'd9, 32'h8000_0000);
    do_write(5'd10, 32'd4);
    do_write(5'd12, 32'd0);
    do_write(5'd13, 32'hF0F0_F0F0);
    do_write(5'd14, 32'hFF00_FF00);
    do_alu(OpSll, 5'd9, 5'd10);
    n_cmp++;
    if (aluResult !== 32'h0 || zero !== 1'b1) begin
      n_err++;
      $display("FAIL sll: actual=%h z%b required=0 z1", aluResult, zero);
    end
    do_alu(OpSrl, 5'd9, 5'd10);
    n_cmp++;
    if (aluResult !== 32'h0800_0000) begin
      n_err++;
      $display("FAIL srl: actual=%h required=08000000", aluResult);
    end
    do_alu(OpSra, 5'd9, 5'd10);
    n_cmp++;
    if (aluResult !== 32'hF800_0000) begin
      n_err++;
      $display("FAIL sra: actual=%h required=f8000000", aluResult);
    end
    do_alu(OpSll, 5'd9, 5'd12);
    n_cmp++;
    if (aluResult !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL sll_by_0: actual=%h required=80000000", aluResult);
    end
    do_alu(OpSra, 5'd13, 5'd12);
    n_cmp++;
    if (aluResult !== 32'hF0F0_F0F0) begin
      n_err++;
      $display("FAIL sra_by_0: actual=%h required=f0f0f0f0", aluResult);
    end
    do_alu(OpAnd, 5'd13, 5'd14);
    n_cmp++;
    if (aluResult !== 32'hF000_F000) begin
      n_err++;
      $display("FAIL and: actual=%h required=f000f000", aluResult);
    end
    do_alu(OpOr, 5'd13, 5'd14);
    n_cmp++;
    if (aluResult !== 32'hFFF0_FFF0) begin
      n_err++;
      $display("FAIL or: actual=%h required=fff0fff0", aluResult);
    end
    do_alu(OpXor, 5'd13, 5'd14);
    n_cmp++;
    if (aluResult !== 32'h0FF0_0FF0) begin
      n_err++;
      $display("FAIL xor: actual=%h required=0ff00ff0", aluResult);
    end
    do_alu(OpNor, 5'd13, 5'd14);
    n_cmp++;
    if (aluResult !== 32'h000F_000F || carry !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL nor: actual=%h c%b v%b required=000f000f c0 v0",
               aluResult, carry, overflow);
    end
    do_alu(OpPassA, 5'd13, 5'd14);
    n_cmp++;
    if (aluResult !== 32'hF0F0_F0F0) begin
      n_err++;
      $display("FAIL passa: actual=%h required=f0f0f0f0", aluResult);
    end
    do_alu(OpPassB, 5'd13, 5'd14);
    n_cmp++;
    if (aluResult !== 32'hFF00_FF00) begin
      n_err++;
      $display("FAIL passb: actual=%h required=ff00ff00", aluResult);
    end
  endtask

  task automatic test_back_to_back();
    // Write and read the same address in one cycle: old value until the edge.
    @(negedge clk);
    registerFileSelect = 1'b1;
    irInput            = mk_ir(OpAdd, 5'd7, 5'd7, 5'd7);
    dataInput          = 32'h0000_1234;
    #1;
    n_cmp++;
    if (regA !== 32'h0 || regB !== 32'h0) begin
      n_err++;
      $display("FAIL wr_same_before: actual=%h/%h required=0/0", regA, regB);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (regA !== 32'h0000_1234 || regB !== 32'h0000_1234) begin
      n_err++;
      $display("FAIL wr_same_after: actual=%h/%h required=1234/1234", regA, regB);
    end
    // Mode switch: ALU capture right after the last write sees that write.
    do_write(5'd8, 32'h0000_00AB);
    do_alu(OpAdd, 5'd8, 5'd7);
    n_cmp++;
    if (aluResult !== 32'h0000_12DF) begin
      n_err++;
      $display("FAIL mode_switch: actual=%h required=000012df", aluResult);
    end
  endtask

  task automatic test_hold_reset();
    do_alu(OpAdd, 5'd0, 5'd1);
    do_write(5'd20, 32'd99);
    do_write(5'd21, 32'd77);
    n_cmp++;
    if (aluResult !== 32'd2 || zero !== 1'b0) begin
      n_err++;
      $display("FAIL hold_write_mode: actual=%h z%b required=2 z0", aluResult, zero);
    end
    // Reset pulse strictly between edges.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (aluResult !== 32'h0 || zero !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: actual=%h z%b required=0 z1", aluResult, zero);
    end
    reset = 1'b0;
    // Reset held across an edge overrides a pending write.
    @(negedge clk);
    registerFileSelect = 1'b1;
    irInput            = mk_ir(OpAdd, 5'd3, 5'd3, 5'd20);
    dataInput          = 32'h0000_0055;
    reset              = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (regA !== 32'h0 || regB !== 32'h0) begin
      n_err++;
      $display("FAIL reset_overrides_write: actual=%h/%h required=0/0", regA, regB);
    end
    @(negedge clk);
    reset = 1'b0;
    do_write(5'd1, 32'd5);
    do_alu(OpPassA, 5'd1, 5'd1);
    n_cmp++;
    if (aluResult !== 32'd5) begin
      n_err++;
      $display("FAIL passa_5: actual=%h required=5", aluResult);
    end
    do_alu(OpBad, 5'd1, 5'd1);
    n_cmp++;
    if (aluResult !== 32'h0 || zero !== 1'b1 || carry !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL undef_op: actual=%h z%b c%b v%b required=0 z1 c0 v0",
               aluResult, zero, carry, overflow);
    end
  endtask

  initial begin
    n_cmp              = 0;
    n_err              = 0;
    reset              = 1'b1;
    registerFileSelect = 1'b0;
    irInput            = 32'h0;
    dataInput          = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_overflow_carry();
    test_sub_slt();
    test_shift_logic();
    test_back_to_back();
    test_hold_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- 32-bit CPU datapath slice: a 32x32 general register file feeding a combinational ALU, with a registered ALU result.
- The instruction word (irInput) supplies the ALU opcode and three 5-bit register addresses.
- registerFileSelect chooses the mode: load external data into the register file, or execute an ALU operation on two registers.

Parameters:
- WIDTH, 32, data/register/instruction width in bits.
- REGS, 32, number of registers; addressed by 5-bit fields.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- irInput  input  WIDTH  instruction word: [31:26] opcode, [25:21] write address, [20:16] read address A, [15:11] read address B; [10:0] ignored.
- dataInput  input  WIDTH  external data written into the register file.
- registerFileSelect  input  1  1 = write mode; 0 = ALU mode.
- regA  output  WIDTH  combinational read of reg[irInput[20:16]].
- regB  output  WIDTH  combinational read of reg[irInput[15:11]].
- aluResult  output  WIDTH  registered ALU result.
- zero  output  1  registered; 1 when the registered aluResult equals 0.
- carry  output  1  registered carry-out of add, or NOT borrow of sub; 0 for other ops.
- overflow  output  1  registered signed overflow of add/sub; 0 for other ops.

Behaviour:
- Reset (asynchronous, active-high):
  - All 32 registers clear to 0.
  - aluResult clears to 0, zero to 1, carry to 0, overflow to 0.
  - Reset asserted mid-operation overrides any pending write or ALU capture.
- Register file:
  - R0 is an ordinary writable register; it is not hardwired to 0.
  - Reads are asynchronous.
  - A write is visible on regA/regB after the writing clock edge, never in the same cycle.
- Write mode (registerFileSelect=1): on each rising edge, reg[irInput[25:21]] <= dataInput. aluResult and all flags hold their values.
- ALU mode (registerFileSelect=0):
  - No register write.
  - On each rising edge, aluResult and the flags capture f(opcode, regA, regB).
  - Latency is 1 cycle from stable operands/opcode to aluResult.
- Opcodes (irInput[31:26]):
  - 000000 ADD: A+B.
  - 000001 SUB: A-B.
  - 000010 AND.
  - 000011 OR.
  - 000100 XOR.
  - 000101 NOR.
  - 000110 SLT: 1 if signed A<B, else 0.
  - 000111 SLL: A << B[4:0].
  - 001000 SRL: A >> B[4:0], logical.
  - 001001 SRA: A >>> B[4:0], arithmetic.
  - 001010 PASSA: A.
  - 001011 PASSB: B.
  - All others: result 0, carry 0, overflow 0.
- Arithmetic rules:
  - Results wrap modulo 2^32.
  - carry is bit 32 of the 33-bit unsigned sum (SUB computes A + ~B + 1).
  - overflow = operand signs equal (with B inverted for SUB) and result sign differs.
- Boundary conditions:
  - Write address equal to a read address in write mode: regA/regB show the old value until the edge, the new value after it.
  - Mode switch from 1 to 0: the first ALU capture uses register contents including the final write.
  - Shift amount 0 returns A unchanged.
- X on unused instruction bits must not affect outputs.

Test Plan:
- Reset: assert reset with nonzero state -> all registers, regA, regB and aluResult read 0; zero=1; carry=0; overflow=0. Deassert -> values hold.
- Write/read: select=1, dataInput=1, write R0 then R1; select=0, opcode ADD, A=R0, B=R1 -> regA=1, regB=1; one edge later aluResult=2, zero=0, carry=0, overflow=0.
- Overflow/carry: R2=0x7FFFFFFF, R3=1, ADD -> aluResult=0x80000000, overflow=1, carry=0. R4=0xFFFFFFFF, R3=1, ADD -> aluResult=0, zero=1, carry=1.
- SUB/SLT: R5=3, R6=5. SUB R5-R6 -> 0xFFFFFFFE, carry=0. SUB R6-R5 -> 2, carry=1. SLT R4(-1),R3(1) -> 1.
- Shifts/logic: A=0x80000000, B=4 -> SLL=0, SRL=0x08000000, SRA=0xF8000000. A=0xF0F0F0F0, B=0xFF00FF00 -> AND=0xF000F000, XOR=0x0FF00FF0, NOR=0x000F000F.
- Hold/async reset: select=1 with aluResult=2 -> aluResult stays 2 across edges. Pulse reset between clock edges -> aluResult=0 immediately, without waiting for an edge. Undefined opcode 111111 -> aluResult=0.
